// File: rtl/ic_ud_counter_n.sv
// Presettable up/down modulo-N counter with wrap, saturate and one-shot modes,
// active-low ripple carry/borrow outputs for cascading stages.
module ic_ud_counter_n #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             C,
    input  logic             R,
    input  logic [WIDTH-1:0] D,
    input  logic             LDn,
    input  logic             CLR,
    input  logic             EN,
    input  logic             CI,
    input  logic             UP,
    input  logic [1:0]       MODE,
    output logic [WIDTH-1:0] Q,
    output logic             CRn,
    output logic             BRn,
    output logic             DONE
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             done_q, done_d;
    logic             step, at_max, at_zero, at_term;

    assign step    = EN & CI & ~done_q;
    assign at_max  = (q_q == MAXV);
    assign at_zero = (q_q == '0);
    assign at_term = UP ? at_max : at_zero;

    always_comb begin
        q_d    = q_q;
        done_d = done_q;
        if (CLR) begin
            q_d    = '0;
            done_d = 1'b0;
        end else if (!LDn) begin
            q_d    = (D > MAXV) ? MAXV : D;
            done_d = 1'b0;
        end else if (step) begin
            if (at_term) begin
                // Saturate holds at terminal; wrap and one-shot roll over.
                if (MODE != 2'b01)
                    q_d = UP ? '0 : MAXV;
            end else begin
                q_d = UP ? (q_q + ONE) : (q_q - ONE);
                if (MODE == 2'b10 && (UP ? (q_q == MAXV - ONE) : (q_q == ONE)))
                    done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            q_q    <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            done_q <= done_d;
        end
    end

    assign Q    = q_q;
    assign DONE = done_q;
    assign CRn  = ~(UP & at_max & step);
    assign BRn  = ~(~UP & at_zero & step);

endmodule

// File: tb/tb_ic_ud_counter_n.sv
// Self-checking bench: directed vector table, async-reset and cascade
// sequences, then randomized stimulus against an arithmetic reference model.
module tb_ic_ud_counter_n;
    localparam int W = 4;
    localparam int M = 10;

    logic         C = 1'b0;
    logic         R;
    logic [W-1:0] D;
    logic         LDn, CLR, EN, CI, UP;
    logic [1:0]   MODE;
    logic [W-1:0] Q;
    logic         CRn, BRn, DONE;

    // cascade pair
    logic         cR, cEN;
    logic [W-1:0] lo_q, hi_q;
    logic         lo_crn, lo_brn, lo_done, hi_crn, hi_brn, hi_done;

    ic_ud_counter_n #(.WIDTH(W), .MODULUS(M)) dut (
        .C(C), .R(R), .D(D), .LDn(LDn), .CLR(CLR), .EN(EN), .CI(CI), .UP(UP),
        .MODE(MODE), .Q(Q), .CRn(CRn), .BRn(BRn), .DONE(DONE));

    ic_ud_counter_n #(.WIDTH(W), .MODULUS(M)) u_lo (
        .C(C), .R(cR), .D(4'd0), .LDn(1'b1), .CLR(1'b0), .EN(cEN), .CI(1'b1), .UP(1'b1),
        .MODE(2'b00), .Q(lo_q), .CRn(lo_crn), .BRn(lo_brn), .DONE(lo_done));

    ic_ud_counter_n #(.WIDTH(W), .MODULUS(M)) u_hi (
        .C(C), .R(cR), .D(4'd0), .LDn(1'b1), .CLR(1'b0), .EN(cEN), .CI(~lo_crn), .UP(1'b1),
        .MODE(2'b00), .Q(hi_q), .CRn(hi_crn), .BRn(hi_brn), .DONE(hi_done));

    always #5 C = ~C;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    typedef struct {
        logic       ldn, clr, en, ci, up;
        logic [1:0] mode;
        logic [3:0] d;
        int         q;
        logic       done, crn, brn;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic ldn, logic clr, logic en, logic ci, logic up,
                                logic [1:0] mode, logic [3:0] d,
                                int q, logic done, logic crn, logic brn);
        vec_t v;
        v.ldn = ldn; v.clr = clr; v.en = en; v.ci = ci; v.up = up;
        v.mode = mode; v.d = d; v.q = q; v.done = done; v.crn = crn; v.brn = brn;
        return v;
    endfunction

    // Reference model: plain modular arithmetic on integers.
    int mq;
    bit mdone;

    task automatic model_edge(input bit ldn, input bit clr, input bit en, input bit ci,
                              input bit up, input bit [1:0] mode, input int d);
        int term, nq;
        term = up ? M - 1 : 0;
        if (clr) begin
            mq = 0; mdone = 0;
        end else if (!ldn) begin
            mq = (d < M) ? d : M - 1; mdone = 0;
        end else if (en && ci && !mdone) begin
            if (mq == term && mode == 2'b01) nq = mq;
            else nq = up ? (mq + 1) % M : (mq + M - 1) % M;
            if (mode == 2'b10 && mq != term && nq == term) mdone = 1;
            mq = nq;
        end
    endtask

    initial begin
        R = 1'b1; cR = 1'b1; cEN = 1'b0;
        D = '0; LDn = 1'b1; CLR = 1'b0; EN = 1'b1; CI = 1'b1; UP = 1'b1; MODE = 2'b00;

        // wrap up 0..9,0,1,2
        for (int i = 1; i <= 12; i++)
            vt.push_back(mk(1, 0, 1, 1, 1, 2'b00, 0, i % M, 0, (i % M) != 9, 1));
        // wrap down with borrow
        vt.push_back(mk(0, 0, 1, 1, 0, 2'b00, 2, 2, 0, 1, 1));
        vt.push_back(mk(1, 0, 1, 1, 0, 2'b00, 0, 1, 0, 1, 1));
        vt.push_back(mk(1, 0, 1, 1, 0, 2'b00, 0, 0, 0, 1, 0));
        vt.push_back(mk(1, 0, 1, 1, 0, 2'b00, 0, 9, 0, 1, 1));
        vt.push_back(mk(1, 0, 1, 1, 0, 2'b00, 0, 8, 0, 1, 1));
        // saturate, load clamp
        vt.push_back(mk(0, 0, 1, 1, 1, 2'b01, 13, 9, 0, 0, 1));
        for (int i = 0; i < 3; i++)
            vt.push_back(mk(1, 0, 1, 1, 1, 2'b01, 0, 9, 0, 0, 1));
        vt.push_back(mk(1, 0, 1, 1, 0, 2'b01, 0, 8, 0, 1, 1));
        // one-shot
        vt.push_back(mk(0, 0, 1, 1, 1, 2'b10, 7, 7, 0, 1, 1));
        vt.push_back(mk(1, 0, 1, 1, 1, 2'b10, 0, 8, 0, 1, 1));
        vt.push_back(mk(1, 0, 1, 1, 1, 2'b10, 0, 9, 1, 1, 1));
        vt.push_back(mk(1, 0, 1, 1, 1, 2'b10, 0, 9, 1, 1, 1));
        vt.push_back(mk(1, 0, 1, 1, 1, 2'b00, 0, 9, 1, 1, 1));
        vt.push_back(mk(0, 0, 1, 1, 1, 2'b10, 3, 3, 0, 1, 1));
        // clear beats load, then count to 5
        vt.push_back(mk(0, 1, 1, 1, 1, 2'b00, 5, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 1, 1, 1, 2'b00, 4, 4, 0, 1, 1));
        vt.push_back(mk(1, 0, 1, 1, 1, 2'b00, 0, 5, 0, 1, 1));

        #2;
        chk("reset_q_async", Q, 0);
        chk("reset_done_async", DONE, 0);
        tick();
        chk("reset_q_held", Q, 0);
        chk("reset_crn", CRn, 1);
        UP = 1'b0;
        #1;
        chk("reset_brn_follows", BRn, 0);
        UP = 1'b1;
        R = 1'b0;

        foreach (vt[i]) begin
            LDn = vt[i].ldn; CLR = vt[i].clr; EN = vt[i].en; CI = vt[i].ci;
            UP = vt[i].up; MODE = vt[i].mode; D = vt[i].d;
            tick();
            chk($sformatf("vec%0d_q", i), Q, vt[i].q);
            chk($sformatf("vec%0d_done", i), DONE, vt[i].done);
            chk($sformatf("vec%0d_crn", i), CRn, vt[i].crn);
            chk($sformatf("vec%0d_brn", i), BRn, vt[i].brn);
        end

        // async reset between edges at Q=5
        UP = 1'b0;
        #2;
        R = 1'b1;
        #1;
        chk("async_rst_q", Q, 0);
        chk("async_rst_brn", BRn, 0);
        chk("async_rst_crn", CRn, 1);
        tick();
        chk("rst_held_q", Q, 0);
        R = 1'b0;
        tick();
        chk("post_rst_wrap_down", Q, 9);
        CI = 1'b0;
        tick();
        chk("ci0_hold_q", Q, 9);
        chk("ci0_brn", BRn, 1);
        chk("ci0_crn", CRn, 1);
        CI = 1'b1;

        // cascade: two decades
        cR = 1'b0;
        cEN = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            chk($sformatf("casc%0d_lo", k), lo_q, k % 10);
            chk($sformatf("casc%0d_hi", k), hi_q, (k / 10) % 10);
        end
        cEN = 1'b0;

        // randomized against model
        R = 1'b1;
        #1;
        R = 1'b0;
        mq = 0; mdone = 0;
        for (int n = 0; n < 600; n++) begin
            R    = ($urandom_range(0, 59) == 0);
            CLR  = ($urandom_range(0, 29) == 0);
            LDn  = ($urandom_range(0, 9) != 0);
            EN   = ($urandom_range(0, 7) != 0);
            CI   = ($urandom_range(0, 7) != 0);
            UP   = ($urandom_range(0, 3) != 0);
            MODE = 2'($urandom_range(0, 3));
            D    = 4'($urandom_range(0, 15));
            #1;
            if (R) begin
                mq = 0; mdone = 0;
                chk("rnd_async_q", Q, 0);
            end
            tick();
            if (!R) model_edge(LDn, CLR, EN, CI, UP, MODE, int'(D));
            chk($sformatf("rnd%0d_q", n), Q, mq);
            chk($sformatf("rnd%0d_done", n), DONE, mdone);
            chk($sformatf("rnd%0d_crn", n), CRn,
                !(UP && mq == M - 1 && EN && CI && !mdone));
            chk($sformatf("rnd%0d_brn", n), BRn,
                !(!UP && mq == 0 && EN && CI && !mdone));
        end
        R = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
